// File: rtl/mac_lane_array.sv
// Multi-lane saturating fixed-point dot-product engine with valid/ready on both sides.
// One broadcast sample per beat; valid_o latency is 1 cycle after the last accepted beat.
module mac_lane_array #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned INT_BITS  = 4,
    parameter int unsigned N_LANES   = 4,
    parameter int unsigned N_INPUTS  = 8,
    parameter int unsigned RELU      = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [WORD_SIZE-1:0]              data_i,
    input  logic [N_LANES*WORD_SIZE-1:0]      mem_i,
    input  logic [N_LANES*WORD_SIZE-1:0]      bias_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [N_LANES*WORD_SIZE-1:0]      data_o,
    output logic [N_LANES-1:0]                sat_o,
    output logic [$clog2(N_INPUTS+1)-1:0]     count_o
);

    localparam int unsigned FRAC_BITS = WORD_SIZE - INT_BITS;
    localparam int unsigned ACC_W     = 2 * WORD_SIZE;
    localparam int unsigned CNT_W     = $clog2(N_INPUTS + 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic {ACCUM, OUT} state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic                           valid_q, valid_d;
    logic                           ready_q, ready_d;
    logic [N_LANES*WORD_SIZE-1:0]   data_q, data_d;
    logic [N_LANES-1:0]             sat_q, sat_d;
    logic [N_LANES-1:0]             sticky_q, sticky_d;
    logic signed [ACC_W-1:0]        acc_q [N_LANES];
    logic signed [ACC_W-1:0]        acc_d [N_LANES];

    logic signed [WORD_SIZE-1:0]    data_s;
    logic                           first_beat;
    logic                           last_beat;
    logic signed [ACC_W-1:0]        acc_new [N_LANES];
    logic [N_LANES-1:0]             sticky_new;
    logic [N_LANES*WORD_SIZE-1:0]   out_flat;
    logic [N_LANES-1:0]             out_sat;

    assign data_s     = data_i;
    assign first_beat = (count_q == '0);
    assign last_beat  = (count_q == CNT_W'(N_INPUTS - 1));

    // Per-lane datapath: saturating accumulate, then shift/clamp/ReLU of the would-be result.
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic signed [WORD_SIZE-1:0] w;
        logic signed [WORD_SIZE-1:0] b;
        logic signed [ACC_W-1:0]     prod;
        logic signed [ACC_W-1:0]     base;
        logic signed [ACC_W:0]       sum;
        logic                        add_ovf;
        logic signed [ACC_W-1:0]     shifted;
        logic                        trunc_hi;
        logic                        trunc_lo;
        logic [WORD_SIZE-1:0]        clamped;

        assign w       = mem_i[g*WORD_SIZE +: WORD_SIZE];
        assign b       = bias_i[g*WORD_SIZE +: WORD_SIZE];
        assign prod    = ACC_W'(w) * ACC_W'(data_s);
        assign base    = first_beat ? (ACC_W'(b) <<< FRAC_BITS) : acc_q[g];
        assign sum     = (ACC_W+1)'(base) + (ACC_W+1)'(prod);
        assign add_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        assign acc_new[g] = add_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
        assign sticky_new[g] = (first_beat ? 1'b0 : sticky_q[g]) | add_ovf;

        assign shifted  = acc_new[g] >>> FRAC_BITS;
        assign trunc_hi = (shifted > OUT_MAX);
        assign trunc_lo = (shifted < OUT_MIN);
        assign clamped  = trunc_hi ? OUT_MAX[WORD_SIZE-1:0] :
                          trunc_lo ? OUT_MIN[WORD_SIZE-1:0] : shifted[WORD_SIZE-1:0];

        // ReLU zeroes negative results but is not counted as saturation.
        assign out_flat[g*WORD_SIZE +: WORD_SIZE] =
            ((RELU != 0) && clamped[WORD_SIZE-1]) ? '0 : clamped;
        assign out_sat[g] = sticky_new[g] | trunc_hi | trunc_lo;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        valid_d  = valid_q;
        ready_d  = ready_q;
        data_d   = data_q;
        sat_d    = sat_q;
        sticky_d = sticky_q;
        for (int k = 0; k < N_LANES; k++) begin
            acc_d[k] = acc_q[k];
        end

        case (state_q)
            ACCUM: begin
                if (valid_i) begin
                    for (int k = 0; k < N_LANES; k++) begin
                        acc_d[k] = acc_new[k];
                    end
                    sticky_d = sticky_new;
                    if (last_beat) begin
                        count_d = '0;
                        state_d = OUT;
                        valid_d = 1'b1;
                        ready_d = 1'b0;
                        data_d  = out_flat;
                        sat_d   = out_sat;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            OUT: begin
                if (ready_i) begin
                    state_d = ACCUM;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ACCUM;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            data_q   <= '0;
            sat_q    <= '0;
            sticky_q <= '0;
            for (int k = 0; k < N_LANES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            sat_q    <= sat_d;
            sticky_q <= sticky_d;
            for (int k = 0; k < N_LANES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sat_o   = sat_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_mac_lane_array.sv
// Bench for mac_lane_array: two instances (RELU=0/1) share stimulus and are
// compared against an integer-arithmetic dot-product reference.
module tb_mac_lane_array;

    localparam int unsigned W  = 16;
    localparam int unsigned NL = 4;
    localparam int unsigned NI = 4;
    localparam int unsigned CW = $clog2(NI + 1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          valid_i;
    logic          ready_i;
    logic [W-1:0]  data_i;
    logic [NL*W-1:0] mem_i;
    logic [NL*W-1:0] bias_i;

    logic            ready0, valid0, ready1, valid1;
    logic [NL*W-1:0] data0, data1;
    logic [NL-1:0]   sat0, sat1;
    logic [CW-1:0]   count0, count1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] vw [NI][NL];
    logic [W-1:0] vd [NI];
    logic [W-1:0] vb [NL];
    logic [NL*W-1:0] exp0, exp1;
    logic [NL-1:0]   exp_sat;

    always #5 clk = ~clk;

    mac_lane_array #(.WORD_SIZE(W), .INT_BITS(4), .N_LANES(NL), .N_INPUTS(NI), .RELU(0)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready0),
        .data_i(data_i), .mem_i(mem_i), .bias_i(bias_i), .valid_o(valid0),
        .ready_i(ready_i), .data_o(data0), .sat_o(sat0), .count_o(count0));

    mac_lane_array #(.WORD_SIZE(W), .INT_BITS(4), .N_LANES(NL), .N_INPUTS(NI), .RELU(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready1),
        .data_i(data_i), .mem_i(mem_i), .bias_i(bias_i), .valid_o(valid1),
        .ready_i(ready_i), .data_o(data1), .sat_o(sat1), .count_o(count1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer dot product in Q.24, clamped to 32 bits per add, then floor to Q.12.
    task automatic compute_expected();
        for (int k = 0; k < NL; k++) begin
            longint acc = longint'($signed(vb[k])) * 4096;
            longint q;
            bit st = 1'b0;
            for (int j = 0; j < NI; j++) begin
                acc += longint'($signed(vw[j][k])) * longint'($signed(vd[j]));
                if (acc > 64'sd2147483647) begin
                    acc = 64'sd2147483647; st = 1'b1;
                end else if (acc < -64'sd2147483648) begin
                    acc = -64'sd2147483648; st = 1'b1;
                end
            end
            q = acc >>> 12;
            if (q > 32767) begin q = 32767; st = 1'b1; end
            else if (q < -32768) begin q = -32768; st = 1'b1; end
            exp_sat[k] = st;
            exp0[k*W +: W] = 16'(q);
            exp1[k*W +: W] = (q < 0) ? 16'h0000 : 16'(q);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_valid0"}, 64'(valid0), 64'd1);
        chk({tag, "_valid1"}, 64'(valid1), 64'd1);
        chk({tag, "_ready0"}, 64'(ready0), 64'd0);
        chk({tag, "_data0"}, 64'(data0), 64'(exp0));
        chk({tag, "_data1"}, 64'(data1), 64'(exp1));
        chk({tag, "_sat0"}, 64'(sat0), 64'(exp_sat));
        chk({tag, "_sat1"}, 64'(sat1), 64'(exp_sat));
        chk({tag, "_count0"}, 64'(count0), 64'd0);
    endtask

    // Drive one vector from vw/vd/vb; later beats carry junk bias, gaps and OUT-state valid_i noise.
    task automatic run_vector(input string tag, input bit gaps, input int bp);
        compute_expected();
        for (int j = 0; j < NI; j++) begin
            chk({tag, "_rdy"}, 64'(ready0 & ready1), 64'd1);
            chk({tag, "_cnt"}, 64'({count0, count1}), 64'({CW'(j), CW'(j)}));
            valid_i = 1'b1;
            data_i  = vd[j];
            for (int k = 0; k < NL; k++) begin
                mem_i[k*W +: W]  = vw[j][k];
                bias_i[k*W +: W] = (j == 0) ? vb[k] : W'($urandom);
            end
            @(posedge clk); #1;
            valid_i = 1'b0;
            data_i  = W'($urandom);
            if (j < NI - 1) begin
                chk({tag, "_early_valid"}, 64'(valid0 | valid1), 64'd0);
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
        end
        chk_outputs(tag);
        valid_i = 1'b1;
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            chk_outputs({tag, "_hold"});
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        valid_i = 1'b0;
        chk({tag, "_done_valid"}, 64'(valid0 | valid1), 64'd0);
        chk({tag, "_done_ready"}, 64'(ready0 & ready1), 64'd1);
        chk({tag, "_done_cnt"}, 64'(count0), 64'd0);
    endtask

    task automatic fill(input logic [W-1:0] w, input logic [W-1:0] d, input logic [W-1:0] b);
        for (int j = 0; j < NI; j++) begin
            vd[j] = d;
            for (int k = 0; k < NL; k++) vw[j][k] = w;
        end
        for (int k = 0; k < NL; k++) vb[k] = b;
    endtask

    function automatic logic [W-1:0] rand_word(input int mode);
        logic [W-1:0] ext [4];
        int r;
        ext[0] = 16'h7FFF; ext[1] = 16'h8000; ext[2] = 16'h7000; ext[3] = 16'h9000;
        case (mode)
            0:       return W'($urandom);
            1: begin r = int'($urandom_range(0, 8191)) - 4096; return W'(r); end
            default: return ext[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        data_i = '0; mem_i = '0; bias_i = '0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        chk("rst_ready", 64'(ready0 & ready1), 64'd1);
        chk("rst_valid", 64'(valid0 | valid1), 64'd0);
        chk("rst_data", 64'(data0 | data1), 64'd0);
        chk("rst_sat", 64'(sat0 | sat1), 64'd0);
        chk("rst_count", 64'(count0 | count1), 64'd0);

        fill(16'h1000, 16'h0800, 16'h0400);
        run_vector("basic", 1'b0, 0);
        chk("basic_l0", 64'(data0[15:0]), 64'h2400);
        chk("basic_sat_l0", 64'(sat0[0]), 64'd0);

        fill(16'h7000, 16'h7000, 16'h0000);
        run_vector("possat", 1'b0, 0);
        chk("possat_l0", 64'(data0[15:0]), 64'h7FFF);
        chk("possat_sat", 64'(sat0), 64'hF);

        fill(16'h9000, 16'h7000, 16'h0000);
        run_vector("negsat", 1'b0, 0);
        chk("negsat_l0", 64'(data0[15:0]), 64'h8000);
        chk("negsat_relu_l0", 64'(data1[15:0]), 64'h0000);
        chk("negsat_sat", 64'(sat1), 64'hF);

        fill(16'h0000, 16'h0000, 16'h0000);
        for (int k = 0; k < NL; k++) vw[0][k] = 16'hFFFF;
        vd[0] = 16'h0001;
        run_vector("floor", 1'b0, 0);
        chk("floor_l0", 64'(data0[15:0]), 64'hFFFF);
        chk("floor_sat", 64'(sat0), 64'h0);

        fill(16'h0000, 16'h1234, 16'hF000);
        run_vector("relu", 1'b0, 0);
        chk("relu_off_l0", 64'(data0[15:0]), 64'hF000);
        chk("relu_on_l0", 64'(data1[15:0]), 64'h0000);
        chk("relu_sat", 64'(sat1), 64'h0);

        fill(16'h1000, 16'h0800, 16'h0400);
        vw[2][1] = 16'h2000; vb[3] = 16'hE000;
        run_vector("bp", 1'b1, 5);

        // Reset mid-vector, with a beat presented in the same cycle as reset.
        fill(16'h1000, 16'h1000, 16'h0000);
        valid_i = 1'b1; data_i = 16'h1000; mem_i = {NL{16'h1000}}; bias_i = '0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0; valid_i = 1'b0;
        chk("midrst_count", 64'(count0 | count1), 64'd0);
        chk("midrst_ready", 64'(ready0 & ready1), 64'd1);
        chk("midrst_valid", 64'(valid0 | valid1), 64'd0);
        fill(16'h1000, 16'h0400, 16'h0000);
        run_vector("postrst", 1'b0, 0);
        chk("postrst_l0", 64'(data0[15:0]), 64'h1000);

        for (int v = 0; v < 60; v++) begin
            int mode = int'($urandom_range(0, 2));
            for (int j = 0; j < NI; j++) begin
                vd[j] = rand_word(mode);
                for (int k = 0; k < NL; k++) vw[j][k] = rand_word(mode);
            end
            for (int k = 0; k < NL; k++) vb[k] = rand_word(mode);
            run_vector("rand", 1'b1, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
